// File: rtl/squarer_seq.sv
// Sequential shift-and-add squarer: Y = X*X over WIDTH cycles through one 2*WIDTH-bit CLA.
// Regenerates a radicand from a root so square-root results can be cross-checked in-system.

// One lookahead group (up to 4 bits): local carries as flat sum-of-products, plus group G/P.
module cla_group #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a_i,
    input  logic [GW-1:0] b_i,
    input  logic          c_i,
    output logic [GW-1:0] s_o,
    output logic          g_o,
    output logic          p_o
);
    logic [GW-1:0] g, p, c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic t;
        c = '0;
        for (int j = 0; j < GW; j++) begin
            t = c_i;
            for (int k = 0; k < j; k++) t = t & p[k];
            c[j] = t;
            for (int k = 0; k < j; k++) begin
                t = g[k];
                for (int m = k + 1; m < j; m++) t = t & p[m];
                c[j] = c[j] | t;
            end
        end
    end

    always_comb begin
        logic t;
        g_o = 1'b0;
        for (int k = 0; k < GW; k++) begin
            t = g[k];
            for (int m = k + 1; m < GW; m++) t = t & p[m];
            g_o = g_o | t;
        end
    end

    assign p_o = &p;
    assign s_o = p ^ c;
endmodule

// N-bit carry-lookahead adder built from 4-bit groups; a narrower last group absorbs N mod 4.
module cla_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] A_i,
    input  logic [N-1:0] B_i,
    input  logic         Ci_i,
    output logic [N-1:0] S_o,
    output logic         Co_o
);
    localparam int NG = (N + 3) / 4;

    logic [NG:0]   gc;
    logic [NG-1:0] gg, gp;

    assign gc[0] = Ci_i;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = 4 * k;
        localparam int GW = (N - LO >= 4) ? 4 : N - LO;

        cla_group #(.GW(GW)) u_grp (
            .a_i (A_i[LO +: GW]),
            .b_i (B_i[LO +: GW]),
            .c_i (gc[k]),
            .s_o (S_o[LO +: GW]),
            .g_o (gg[k]),
            .p_o (gp[k])
        );

        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    assign Co_o = gc[NG];
endmodule

module squarer_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     X_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   Y_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] p, m, sum, p_nxt;
    logic [WIDTH-1:0]   q;
    logic [CW-1:0]      cnt;
    logic               add_co;

    cla_adder #(.N(2*WIDTH)) u_cla (
        .A_i  (p),
        .B_i  (m),
        .Ci_i (1'b0),
        .S_o  (sum),
        .Co_o (add_co)
    );

    assign p_nxt = q[0] ? sum : p;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            p     <= '0;
            m     <= '0;
            q     <= '0;
            cnt   <= '0;
            Y_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        p     <= '0;
                        m     <= {{WIDTH{1'b0}}, X_i};
                        q     <= X_i;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    p   <= p_nxt;
                    m   <= m << 1;
                    q   <= q >> 1;
                    cnt <= cnt + CW'(1);
                    // Last iteration publishes the sum including this cycle's addend.
                    if (cnt == LAST) begin
                        Y_o   <= p_nxt;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state == S_CALC) || (state == S_DONE);
    assign done_o = (state == S_DONE);

`ifndef SYNTHESIS
    // (2^W-1)^2 < 2^(2W): the accumulator can never carry out.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_CALC && q[0]) assert (!add_co);
    end
`endif
endmodule

// File: tb/tb_squarer_seq.sv
// Scoreboard bench for squarer_seq: driver pushes X*X with its expected done cycle,
// monitor pops and compares on every done_o.
module tb_squarer_seq;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] y;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   xin;
    logic           busy, done;
    logic [2*W-1:0] y;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    squarer_seq #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .X_i     (xin),
        .busy_o  (busy),
        .done_o  (done),
        .Y_o     (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model_sq(input logic [W-1:0] x);
        int v;
        v = int'(x) * int'(x);
        return v[2*W-1:0];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One request from IDLE; optional ignored start pulses (X=0x50) in CALC and in DONE.
    task automatic op(input logic [W-1:0] x, input bit pulse_calc, input bit pulse_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        xin   = x;
        e.y   = model_sq(x);
        e.cyc = cyc + W + 1;
        sb.push_back(e);
        @(posedge clk);
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            start = (pulse_calc && i == 3) || (pulse_done && i == W + 1);
            xin   = start ? 8'h50 : W'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_seen", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] tv[6];
        exp_t         e;
        int           n0;
        tv = '{8'h01, 8'h10, 8'h0F, 8'hFF, 8'hB5, 8'hAA};

        rst = 1'b1; start = 1'b0; xin = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(y), 0);
        @(negedge clk);
        rst = 1'b0;

        busy_cnt = 0;
        op(8'h00, 0, 0);
        chk("busy_cycles", busy_cnt, W + 1);

        foreach (tv[i]) op(tv[i], 0, 0);

        op(8'h03, 1, 1);
        op(8'h50, 0, 0);
        op(8'h0C, 0, 0);

        // Abort 0xFF mid-CALC with an asynchronous reset between edges.
        @(negedge clk);
        start = 1'b1; xin = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_y", int'(y), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        op(8'h07, 0, 0);

        // Held start: restart every W+2 cycles.
        @(negedge clk);
        start = 1'b1; xin = 8'h02;
        n0 = cyc;
        for (int k = 0; k < 4; k++) begin
            e.y   = model_sq(8'h02);
            e.cyc = n0 + k * (W + 2) + W + 1;
            sb.push_back(e);
        end
        repeat (3 * (W + 2) + 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        chk("held_all_done", sb.size(), 0);

        for (int r = 0; r < 20; r++)
            op(W'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/squarer_seq.md
# squarer_seq

Sequential shift-and-add squarer that computes Y = X² for an unsigned WIDTH-bit operand over WIDTH clock cycles. It is the inverse operation of the square-root datapath: it regenerates the radicand from a root so results can be cross-checked in-system. It reuses one 2·WIDTH-bit carry-lookahead adder per iteration; with the default WIDTH = 8 this is the team's 16-bit CLA. A start/done handshake controls it.

## Interface
- WIDTH, default 8: operand width in bits. The result width is 2·WIDTH. The adder is 2·WIDTH bits wide; at WIDTH = 8 the 16-bit CLA is instantiated with Ci_i tied to 0.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- X_i  in  WIDTH  unsigned operand; sampled on the accepting edge only.
- busy_o  out  1  high while in CALC or DONE.
- done_o  out  1  one-cycle pulse; Y_o is valid and new while high.
- Y_o  out  2·WIDTH  unsigned result X_i²; holds until the next done_o.

## Operation
- Registers:
  - P (2·WIDTH) accumulator.
  - M (2·WIDTH) shifted multiplicand.
  - Q (WIDTH) multiplier shift register.
  - cnt, width ceil(log2(WIDTH+1)).
  - state ∈ {IDLE, CALC, DONE}.
  - Y_o.
- IDLE:
  - start_i = 0: stay in IDLE.
  - start_i = 1: P ← 0, M ← zero-extended X_i, Q ← X_i, cnt ← 0, go to CALC.
- CALC, each cycle:
  - If Q[0] = 1, P ← P + M through the CLA (carry-out discarded). Otherwise P is unchanged.
  - M ← M << 1, Q ← Q >> 1, cnt ← cnt + 1.
  - On the cycle where cnt = WIDTH−1: Y_o ← final P (including that cycle's addend), go to DONE.
- DONE: done_o = 1 for exactly one cycle, then go unconditionally to IDLE.
- Width rule: X² ≤ (2^WIDTH−1)² < 2^(2·WIDTH), so the 2·WIDTH-bit accumulator never overflows. Co_o of the CLA is always 0 in legal operation.
- start_i while busy_o = 1 (CALC or DONE) is ignored. The request is not queued.
- X_i changes after the accepting edge have no effect on the running computation.
- No early termination: latency is fixed, including for X = 0.

## Timing
- Reset (asynchronous, immediate): state = IDLE, busy_o = 0, done_o = 0, Y_o = 0. P, M, Q and cnt are cleared.
- Reset mid-operation aborts the computation. Y_o reads 0, no done_o is produced, and the block is in IDLE after release.
- Let edge 0 be the rising edge that samples start_i = 1 in IDLE:
  - busy_o rises after edge 0.
  - CALC iterations occur on edges 1..WIDTH.
  - At edge WIDTH the block enters DONE: Y_o is updated and done_o rises.
  - done_o falls and busy_o falls after edge WIDTH+1.
- Latency: done_o is high during cycle WIDTH after acceptance (8 cycles at the default WIDTH).
- Throughput: a new start_i can be accepted at edge WIDTH+2 at the earliest (one request per WIDTH+2 cycles). A start_i held high continuously restarts at that edge.
- busy_o and done_o are decoded from the state register, so they are glitch-free registered outputs.

## Test plan
- Reset, then X_i = 0x00 with a start pulse → done_o after 8 cycles, Y_o = 0x0000, busy_o high for exactly 9 cycles.
- X_i = 0x01 → Y_o = 0x0001. X_i = 0x10 → Y_o = 0x0100. X_i = 0x0F → Y_o = 0x00E1.
- X_i = 0xFF → Y_o = 0xFE01 (maximum value, no overflow). X_i = 0xB5 → Y_o = 0x7FF9. X_i = 0xAA → Y_o = 0x70E4.
- Start with X_i = 0x03, then pulse start_i with X_i = 0x50 during CALC and during DONE → Y_o = 0x0009 with a single done_o. A following start in IDLE with 0x50 → Y_o = 0x1900.
- Complete 0x0C (Y_o = 0x0090). Then start 0xFF and assert rst_i asynchronously mid-CALC (between edges) → outputs go to 0 immediately, no done_o. After release, X_i = 0x07 → Y_o = 0x0031.
- start_i held high continuously with X_i = 0x02 → done_o pulses every 10 cycles, Y_o = 0x0004 each time.
